mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Shares one 4:1 4-bit mux datapath among four valid/ready requesters.
- Round-robin arbitration drives the 2-bit mux select. The selected word is captured into a single output register.
- Sits between four producer channels and one consumer channel, with full backpressure on both sides.

Parameters:
- WIDTH, 4, data width of each requester and of the output.
- N is fixed at 4 (not a parameter). The select is 2 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is sampled on clk
- in_valid  input  4  per-requester valid; bit i belongs to requester i
- in_data  input  4*WIDTH  requester i data is in_data[i*WIDTH +: WIDTH]
- in_ready  output  4  one-hot or zero; bit i means requester i's word is taken this cycle
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered mux output
- out_sel  output  2  index of the requester that produced out_data
- out_ready  input  1  consumer accepts the word when out_valid && out_ready

Behaviour:
- Reset (rst_n=0, async):
  - out_valid=0, out_data=0, out_sel=0, last_grant pointer=3.
  - in_ready is combinational and is 0 while out_valid=0 and in_valid=0.
- Slot free: free = !out_valid || out_ready (combinational).
- Arbitration is combinational each cycle:
  - Search in_valid starting at (last_grant+1) mod 4 and ascending with wrap. The first set bit is the grant g.
  - If free and any in_valid, then in_ready = one-hot(g). Otherwise in_ready = 0.
- On a clk edge with free && |in_valid:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - last_grant <= g
- On a clk edge with free && !|in_valid:
  - out_valid <= 0
  - out_data and out_sel hold.
  - last_grant holds.
- On a clk edge with !free, all registers hold (stall).
- Latency: a word accepted on input cycle t appears on out_valid/out_data at cycle t+1.
- Throughput: 1 word/cycle when out_ready stays high.
- Simultaneous output accept and new grant in the same cycle is required (pass-through refill, no bubble).
- Fairness: with all four in_valid held high and out_ready=1, grants cycle 0,1,2,3,0,... Every requester is served within 4 transfers.
- Wrap-around: last_grant=3 searches 0,1,2,3. last_grant=2 searches 3,0,1,2.
- A single requester alone is granted every free cycle; the pointer never skips it.
- in_valid may drop without handshake. Arbitration re-evaluates every cycle, and a non-granted request is never latched.
- Reset mid-transfer: the pending output word is discarded (out_valid=0) and the pointer returns to 3. No in_ready while rst_n=0.
- No X propagation: out_data is driven from registers only, and in_ready depends only on in_valid, out_valid, out_ready and last_grant.

Optional Feature:
- Macro: MUX4_ARB_FIXED_PRIO_EN
- Defined:
  - Fixed priority: requester 3 highest, then 2, 1, 0. This matches a descending if/else-if select chain.
  - last_grant is not used for arbitration. It is still updated so out_sel is unchanged.
  - All other timing is identical.
- Undefined: round-robin as described above (default build).

Test Plan:
- Reset check: rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. Release rst_n, then at the first edge out_sel=0 is granted first.
- Full round-robin: in_valid=4'b1111, data words 4'hA/4'hB/4'hC/4'hD, out_ready=1 -> out_sel sequence 0,1,2,3,0 and out_data A,B,C,D,A on consecutive cycles, with no bubbles.
- Backpressure: out_valid=1 holding 4'hB from sel=1, out_ready=0 for 3 cycles, in_valid=4'b1101 -> in_ready=0 and out_data stays B. When out_ready=1, the same cycle gives in_ready=4'b0100 (grant 2). The next cycle gives out_data=C, out_sel=2.
- Wrap/skip: last_grant=2, in_valid=4'b0101 -> grant 0 (3 is idle). The next cycle with in_valid=4'b0101 -> grant 2.
- Idle drain: one request on 1 (data 4'h7), then in_valid=0 with out_ready=1 -> out_valid goes 1 for one cycle, then 0. out_data stays 7 and out_sel stays 1.
- Fixed-prio build (MUX4_ARB_FIXED_PRIO_EN): in_valid=4'b1111 with out_ready=1 for 4 cycles -> out_sel=3 every cycle and in_ready=4'b1000 every cycle.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: valid/ready bundle between four producers and one consumer
//   in_valid/in_data/in_ready : four producer channels, requester i on bit/word i
//   out_valid/out_data/out_sel/out_ready : registered consumer channel
//   slave modport is the arbiter side, master modport is the environment side
interface mux4_rr_arbiter_if #(parameter int WIDTH = 4);
   logic [3:0]         in_valid;
   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_sel;
   logic               out_ready;
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin 4:1 mux feeding one registered valid/ready output slot
//   clk   : rising-edge clock
//   rst_n : async active-low reset, deassertion sampled on clk
//   bus   : mux4_rr_arbiter_if.slave (four requesters in, one consumer out)
//   MUX4_ARB_FIXED_PRIO_EN : when defined, fixed priority 3 > 2 > 1 > 0 replaces round-robin
module mux4_rr_arbiter #(parameter int WIDTH = 4) (
   input  logic clk,
   input  logic rst_n,
   mux4_rr_arbiter_if.slave bus
);
   logic [1:0]       last_grant, grant;
   logic             any, free, take;
   logic [WIDTH-1:0] word;
`ifdef MUX4_ARB_FIXED_PRIO_EN
   assign grant = bus.in_valid[3] ? 2'd3 : bus.in_valid[2] ? 2'd2 : bus.in_valid[1] ? 2'd1 : 2'd0;
`else
   // Walk from the farthest candidate back to last_grant+1 so the nearest set bit wins.
   always_comb begin
      grant = last_grant;
      for (int k = 4; k >= 1; k--)
         if (bus.in_valid[last_grant + 2'(k)]) grant = last_grant + 2'(k);
   end
`endif
   assign any  = |bus.in_valid;
   assign free = !bus.out_valid || bus.out_ready;
   // rst_n gating keeps in_ready low while reset is held, even though the slot looks free.
   assign take = rst_n && free && any;
   assign bus.in_ready = take ? 4'(1) << grant : 4'd0;
   assign word = bus.in_data[grant*WIDTH +: WIDTH];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= 2'd0;
         last_grant    <= 2'd3;
      end else if (take) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= word;
         bus.out_sel   <= grant;
         last_grant    <= grant;
      end else if (free) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   mux4_rr_arbiter_if #(.WIDTH(4)) bus ();
   mux4_rr_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_ready(input string name, input logic [3:0] exp);
      #1;
      checks++;
      if (bus.in_ready !== exp) begin
         errors++;
         $display("FAIL %s in_ready got=%b exp=%b", name, bus.in_ready, exp);
      end
   endtask
   task automatic chk_out(input string name, input logic v, input logic [3:0] d, input logic [1:0] s);
      checks++;
      if (bus.out_valid !== v || bus.out_data !== d || bus.out_sel !== s) begin
         errors++;
         $display("FAIL %s out got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                  name, bus.out_valid, bus.out_data, bus.out_sel, v, d, s);
      end
   endtask
   task automatic test_reset();
      bus.in_valid  = 4'b1111;
      bus.in_data   = 16'hDCBA;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) edge_step();
      chk_ready("rst_no_ready", 4'b0000);
      chk_out("rst_regs", 1'b0, 4'h0, 2'd0);
      rst_n = 1'b1;
`ifdef MUX4_ARB_FIXED_PRIO_EN
      chk_ready("rst_first_grant", 4'b1000);
`else
      chk_ready("rst_first_grant", 4'b0001);
`endif
   endtask
   task automatic test_round_robin();
      logic [3:0] exp_d [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
      for (int i = 0; i < 5; i++) begin
         chk_ready("rr_grant", 4'(1) << (i % 4));
         edge_step();
         chk_out("rr_out", 1'b1, exp_d[i % 4], 2'(i % 4));
      end
   endtask
   task automatic test_backpressure();
      bus.in_valid = 4'b0010;
      chk_ready("bp_load", 4'b0010);
      edge_step();
      chk_out("bp_load_out", 1'b1, 4'hB, 2'd1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         chk_ready("bp_stall_ready", 4'b0000);
         edge_step();
         chk_out("bp_stall_out", 1'b1, 4'hB, 2'd1);
      end
      bus.out_ready = 1'b1;
      chk_ready("bp_release_ready", 4'b0100);
      edge_step();
      chk_out("bp_release_out", 1'b1, 4'hC, 2'd2);
   endtask
   task automatic test_wrap_skip();
      bus.in_valid = 4'b0101;
      chk_ready("wrap_grant0", 4'b0001);
      edge_step();
      chk_out("wrap_out0", 1'b1, 4'hA, 2'd0);
      chk_ready("wrap_grant2", 4'b0100);
      edge_step();
      chk_out("wrap_out2", 1'b1, 4'hC, 2'd2);
   endtask
   task automatic test_idle_drain();
      bus.in_data  = 16'hDC7A;
      bus.in_valid = 4'b0010;
      chk_ready("drain_grant1", 4'b0010);
      edge_step();
      chk_out("drain_word", 1'b1, 4'h7, 2'd1);
      bus.in_valid = 4'b0000;
      chk_ready("drain_idle_ready", 4'b0000);
      edge_step();
      chk_out("drain_empty", 1'b0, 4'h7, 2'd1);
      edge_step();
      chk_out("drain_stay_empty", 1'b0, 4'h7, 2'd1);
   endtask
   task automatic test_single();
      bus.in_data  = 16'hDCBA;
      bus.in_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         chk_ready("single_grant", 4'b0100);
         edge_step();
         chk_out("single_out", 1'b1, 4'hC, 2'd2);
      end
   endtask
   task automatic test_reset_mid();
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_out("rstmid_discard", 1'b0, 4'h0, 2'd0);
      chk_ready("rstmid_no_ready", 4'b0000);
      edge_step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      chk_ready("rstmid_ptr3", 4'b0001);
      edge_step();
      chk_out("rstmid_first", 1'b1, 4'hA, 2'd0);
   endtask
   task automatic test_fixed_prio();
      for (int i = 0; i < 4; i++) begin
         chk_ready("fixed_grant", 4'b1000);
         edge_step();
         chk_out("fixed_out", 1'b1, 4'hD, 2'd3);
      end
   endtask
   initial begin
      test_reset();
`ifdef MUX4_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
      test_backpressure();
      test_wrap_skip();
      test_idle_drain();
      test_single();
      test_reset_mid();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
